// File: rtl/led_panel_pkg.sv
// led_panel_pkg: shared colour indices, default geometry and conditioned-input slots.
package led_panel_pkg;
   localparam int RED = 0;
   localparam int GREEN = 1;
   localparam int BLUE = 2;
   localparam int COLS_DEF = 32;
   localparam int ROW_BITS_DEF = 4;
   localparam int SIG_SCLK = 3;
   localparam int SIG_LATCH = 4;
   localparam int SIG_ACLK = 5;
   localparam int SIG_ARST = 6;
   localparam int SIG_BLANK = 7;
   localparam int NSIG = 8;
endpackage

// File: rtl/led_panel_capture_if.sv
// led_panel_capture_if: captured-line handshake between the capture block and its consumer.
interface led_panel_capture_if
   import led_panel_pkg::*;
#(
   parameter int COLS = COLS_DEF,
   parameter int ROW_BITS = ROW_BITS_DEF
) ();
   logic                wr_valid;
   logic                wr_ready;
   logic [ROW_BITS-1:0] wr_row;
   logic [COLS-1:0]     wr_red;
   logic [COLS-1:0]     wr_green;
   logic [COLS-1:0]     wr_blue;
   modport master (output wr_valid, wr_row, wr_red, wr_green, wr_blue, input wr_ready);
   modport slave (input wr_valid, wr_row, wr_red, wr_green, wr_blue, output wr_ready);
endinterface

// File: rtl/led_sig_edge.sv
// led_sig_edge: samples one asynchronous input, giving its level and a one-cycle rise strobe.
// LED_PANEL_CAPTURE_SYNC_EN inserts a 2-flop synchronizer ahead of the sample flop.
module led_sig_edge (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_level,
   output logic o_rise
);
   logic w_d;
   logic r_smp;
   logic r_prev;
`ifdef LED_PANEL_CAPTURE_SYNC_EN
   logic [1:0] r_sync;
   always_ff @(posedge clk)
      r_sync <= reset ? 2'b00 : {r_sync[0], i_d};
   assign w_d = r_sync[1];
`else
   assign w_d = i_d;
`endif
   always_ff @(posedge clk)
      if (reset) begin
         r_smp <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_smp <= w_d;
         r_prev <= r_smp;
      end
   assign o_level = r_smp;
   assign o_rise = r_smp & ~r_prev;
endmodule

// File: rtl/led_panel_capture.sv
// led_panel_capture: rebuilds shifted LED panel lines and hands them to a valid/ready consumer.
// Define LED_PANEL_CAPTURE_SYNC_EN to synchronize every *_in (rise latency 3 instead of 1).
module led_panel_capture
   import led_panel_pkg::*;
#(
   parameter int COLS = COLS_DEF,
   parameter int ROW_BITS = ROW_BITS_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic red_in,
   input  logic green_in,
   input  logic blue_in,
   input  logic sclk_in,
   input  logic latch_in,
   input  logic aclk_in,
   input  logic arst_in,
   input  logic blank_in,
   led_panel_capture_if.master wr,
   output logic len_err,
   output logic ovf_err,
   output logic blank_out
);
   localparam int CW = $clog2(2 * COLS + 1);
   localparam logic [CW-1:0] FULL = CW'(COLS);
   localparam logic [CW-1:0] MAXC = CW'(2 * COLS);
   logic [NSIG-1:0]     w_in, w_lvl, w_rise;
   logic [COLS-1:0]     r_sh [3];
   logic [CW-1:0]       r_cnt;
   logic [ROW_BITS-1:0] r_row;
   logic                w_sclk, w_latch, w_load, w_unused;
   // Data bits go through the same conditioning so they stay aligned with sclk.
   assign w_in = {blank_in, arst_in, aclk_in, latch_in, sclk_in, blue_in, green_in, red_in};
   for (genvar i = 0; i < NSIG; i++) begin : g_sig
      led_sig_edge u_edge (.clk(clk), .reset(reset), .i_d(w_in[i]), .o_level(w_lvl[i]), .o_rise(w_rise[i]));
   end
   assign w_sclk = w_rise[SIG_SCLK];
   assign w_latch = w_rise[SIG_LATCH];
   assign w_load = w_latch & (~wr.wr_valid | wr.wr_ready);
   assign w_unused = ^{w_rise[BLUE:RED], w_rise[SIG_BLANK:SIG_ARST], w_lvl[SIG_ACLK:SIG_SCLK]};
   assign blank_out = w_lvl[SIG_BLANK];
   always_ff @(posedge clk)
      if (reset) begin
         r_sh <= '{default: '0};
         r_cnt <= '0;
         r_row <= '0;
         len_err <= 1'b0;
         ovf_err <= 1'b0;
         wr.wr_valid <= 1'b0;
         wr.wr_row <= '0;
         wr.wr_red <= '0;
         wr.wr_green <= '0;
         wr.wr_blue <= '0;
      end else begin
         for (int c = 0; c < 3; c++)
            if (w_sclk) r_sh[c] <= {r_sh[c][COLS-2:0], w_lvl[c]};
         // A shift coinciding with the latch is the first bit of the next line.
         r_cnt <= w_latch ? CW'(w_sclk) : (w_sclk && r_cnt != MAXC) ? r_cnt + CW'(1) : r_cnt;
         r_row <= w_lvl[SIG_ARST] ? '0 : r_row + ROW_BITS'(w_rise[SIG_ACLK]);
         len_err <= w_latch && r_cnt != FULL;
         ovf_err <= w_latch && wr.wr_valid && !wr.wr_ready;
         wr.wr_valid <= w_load | (wr.wr_valid & ~wr.wr_ready);
         if (w_load) begin
            wr.wr_row <= r_row;
            wr.wr_red <= r_sh[RED];
            wr.wr_green <= r_sh[GREEN];
            wr.wr_blue <= r_sh[BLUE];
         end
      end
endmodule
